// File: rtl/move_controller_pkg.sv
// Shared Connect-4 board geometry, piece codes and controller state encodings.
package connect4_pkg;

  localparam int COLS  = 7;
  localparam int ROWS  = 7;
  localparam int CELLS = ROWS * COLS;

  localparam logic [2:0] COL_LIMIT  = 3'(COLS);
  localparam logic [2:0] TOP_ROW    = 3'(ROWS - 1);
  localparam logic [5:0] LAST_CELL  = 6'(CELLS - 1);
  localparam logic [5:0] CELL_COUNT = 6'(CELLS);

  localparam logic [1:0] PIECE_EMPTY = 2'b00;
  localparam logic [1:0] PIECE_P1    = 2'b01;
  localparam logic [1:0] PIECE_P2    = 2'b10;

  typedef logic [2:0] state_t;

  localparam state_t S_CLEAR  = 3'd0;
  localparam state_t S_IDLE   = 3'd1;
  localparam state_t S_READ   = 3'd2;
  localparam state_t S_CHECK  = 3'd3;
  localparam state_t S_WRITE  = 3'd4;
  localparam state_t S_REJECT = 3'd5;

  function automatic logic [5:0] cell_addr(input logic [2:0] row, input logic [2:0] col);
    return 6'(row) * 6'(COLS) + 6'(col);
  endfunction

  function automatic logic [1:0] piece_code(input logic turn);
    return turn ? PIECE_P2 : PIECE_P1;
  endfunction

endpackage

// File: rtl/move_controller_if.sv
// Move handshake, game status and board-RAM port bundle; master = controller side.
interface move_controller_if;
  logic       new_game;
  logic       move_valid;
  logic [2:0] move_col;
  logic       move_ready;
  logic       move_accept;
  logic       move_reject;
  logic       turn;
  logic [2:0] last_row;
  logic [2:0] last_col;
  logic [5:0] moves_made;
  logic       board_full;
  logic       board_enable;
  logic       ram_sel;
  logic [5:0] ram_address;
  logic [1:0] ram_data;
  logic       ram_wren;
  logic [1:0] ram_q;

  modport master (
    input  new_game, move_valid, move_col, ram_q,
    output move_ready, move_accept, move_reject, turn, last_row, last_col,
           moves_made, board_full, board_enable, ram_sel, ram_address,
           ram_data, ram_wren
  );

  modport slave (
    output new_game, move_valid, move_col, ram_q,
    input  move_ready, move_accept, move_reject, turn, last_row, last_col,
           moves_made, board_full, board_enable, ram_sel, ram_address,
           ram_data, ram_wren
  );
endinterface

// File: rtl/move_controller_turn_timer.sv
// Idle-turn forfeit timer; the whole module only exists when TURN_TIMER_EN is defined.
`ifdef TURN_TIMER_EN
module turn_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic expire_o
);
  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  assign expire_o = run_i && (cnt_q == '0);

  // Down-counter: any pause in running reloads, so the window restarts from full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RELOAD;
    end else if (!run_i || cnt_q == '0) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end
endmodule
`endif

// File: rtl/move_controller.sv
// Connect-4 board write sequencer and RAM arbiter; optional idle forfeit via TURN_TIMER_EN.
//   state  | meaning
//   CLEAR  | writing empty code to every cell, one per cycle
//   IDLE   | reader owns RAM, waiting for new_game or a move
//   READ   | presenting address of the probed cell
//   CHECK  | ram_q holds probed cell; empty -> write, else next row
//   WRITE  | writing current player's piece
//   REJECT | one-cycle reject pulse, nothing written
module move_controller
  import connect4_pkg::*;
`ifdef TURN_TIMER_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd50_000_000
)
`endif
(
  input logic              clk,
  input logic              rst_n,
  move_controller_if.master ctl_if
);

  state_t     state_q, state_d;
  logic [5:0] addr_q, addr_d;
  logic [2:0] col_q, col_d;
  logic [2:0] row_q, row_d;
  logic       turn_q, turn_d;
  logic [5:0] moves_q, moves_d;
  logic [2:0] last_row_q, last_row_d;
  logic [2:0] last_col_q, last_col_d;
  logic       timer_expire;

`ifdef TURN_TIMER_EN
  logic timer_run;

  // A handshake or a new game in this cycle counts as activity, not idle time.
  assign timer_run = (state_q == S_IDLE) && !ctl_if.new_game && !ctl_if.move_valid;

  turn_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_turn_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run_i   (timer_run),
    .expire_o(timer_expire)
  );
`else
  assign timer_expire = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    col_d      = col_q;
    row_d      = row_q;
    turn_d     = turn_q;
    moves_d    = moves_q;
    last_row_d = last_row_q;
    last_col_d = last_col_q;
    case (state_q)
      S_CLEAR: begin
        addr_d = addr_q + 6'd1;
        if (addr_q == LAST_CELL) begin
          state_d = S_IDLE;
          addr_d  = 6'd0;
          turn_d  = 1'b0;
          moves_d = 6'd0;
        end
      end
      S_IDLE: begin
        if (ctl_if.new_game) begin
          state_d = S_CLEAR;
          addr_d  = 6'd0;
        end else if (ctl_if.move_valid) begin
          if (ctl_if.move_col >= COL_LIMIT) begin
            state_d = S_REJECT;
          end else begin
            col_d   = ctl_if.move_col;
            row_d   = 3'd0;
            state_d = S_READ;
          end
        end else if (timer_expire) begin
          turn_d = ~turn_q;
        end
      end
      S_READ: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (ctl_if.ram_q == PIECE_EMPTY) begin
          state_d = S_WRITE;
        end else if (row_q == TOP_ROW) begin
          state_d = S_REJECT;
        end else begin
          row_d   = row_q + 3'd1;
          state_d = S_READ;
        end
      end
      S_WRITE: begin
        last_row_d = row_q;
        last_col_d = col_q;
        moves_d    = moves_q + 6'd1;
        turn_d     = ~turn_q;
        state_d    = S_IDLE;
      end
      S_REJECT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_CLEAR;
        addr_d  = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CLEAR;
      addr_q     <= 6'd0;
      col_q      <= 3'd0;
      row_q      <= 3'd0;
      turn_q     <= 1'b0;
      moves_q    <= 6'd0;
      last_row_q <= 3'd0;
      last_col_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      col_q      <= col_d;
      row_q      <= row_d;
      turn_q     <= turn_d;
      moves_q    <= moves_d;
      last_row_q <= last_row_d;
      last_col_q <= last_col_d;
    end
  end

  // Everything outside IDLE owns the RAM, so the reader's sweep restarts after each move.
  assign ctl_if.move_ready   = (state_q == S_IDLE);
  assign ctl_if.board_enable = (state_q == S_IDLE);
  assign ctl_if.ram_sel      = (state_q != S_IDLE);
  assign ctl_if.move_accept  = (state_q == S_WRITE);
  assign ctl_if.move_reject  = (state_q == S_REJECT) || timer_expire;
  assign ctl_if.ram_wren     = (state_q == S_CLEAR) || (state_q == S_WRITE);
  assign ctl_if.ram_data     = (state_q == S_WRITE) ? piece_code(turn_q) : PIECE_EMPTY;
  assign ctl_if.ram_address  = (state_q == S_CLEAR) ? addr_q : cell_addr(row_q, col_q);
  assign ctl_if.turn         = turn_q;
  assign ctl_if.last_row     = last_row_q;
  assign ctl_if.last_col     = last_col_q;
  assign ctl_if.moves_made   = moves_q;
  assign ctl_if.board_full   = (moves_q == CELL_COUNT);

endmodule

// File: tb/tb_move_controller.sv
// Self-checking bench for move_controller: board RAM model plus a column-height game model.
module tb_move_controller;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  move_controller_if bus();

`ifdef TURN_TIMER_EN
  move_controller #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst_n(rst_n), .ctl_if(bus));
`else
  move_controller dut (.clk(clk), .rst_n(rst_n), .ctl_if(bus));
`endif

  logic [1:0] mem [64] = '{default: 2'b11};
  logic [5:0] addr_r = 6'd0;

  always @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
    addr_r <= bus.ram_address;
  end
  assign bus.ram_q = mem[addr_r];

  int n_checks = 0;
  int n_fail   = 0;

  int         heights [7];
  logic [1:0] cells   [49];
  int         m_turn;
  int         m_moves;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 7; c++) heights[c] = 0;
    for (int i = 0; i < 49; i++) cells[i] = 2'b00;
    m_turn  = 0;
    m_moves = 0;
  endtask

  // Called at the negedge where the first clear write (address 0) is visible.
  task automatic clear_check();
    for (int i = 0; i < 49; i++) begin
      chk("clr_wren", 32'(bus.ram_wren), 32'd1);
      chk("clr_addr", 32'(bus.ram_address), 32'(i));
      chk("clr_data", 32'(bus.ram_data), 32'd0);
      @(negedge clk);
    end
    model_reset();
    chk("clr_ready", 32'(bus.move_ready), 32'd1);
    chk("clr_benable", 32'(bus.board_enable), 32'd1);
    chk("clr_ramsel", 32'(bus.ram_sel), 32'd0);
    chk("clr_turn", 32'(bus.turn), 32'd0);
    chk("clr_moves", 32'(bus.moves_made), 32'd0);
  endtask

  task automatic new_game();
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
    clear_check();
  endtask

  task automatic compare_board();
    for (int i = 0; i < 49; i++) chk("board_cell", 32'(mem[i]), 32'(cells[i]));
  endtask

  task automatic do_move(input int col);
    bit   legal;
    int   row;
    int   n;
    int   writes;
    bit   done;
    bit   acc;
    bit   rej;
    logic [5:0] waddr;
    logic [1:0] wdata;
    legal  = (col < 7) && (heights[col < 7 ? col : 0] < 7);
    row    = (col < 7) ? heights[col] : 0;
    n      = 0;
    writes = 0;
    done   = 0;
    acc    = 0;
    rej    = 0;
    waddr  = '0;
    wdata  = '0;
    chk("ready_pre", 32'(bus.move_ready), 32'd1);
    bus.move_valid = 1'b1;
    bus.move_col   = 3'(col);
    @(negedge clk);
    bus.move_valid = 1'b0;
    for (int k = 1; k <= 20 && !done; k++) begin
      if (bus.ram_wren) begin
        writes++;
        waddr = bus.ram_address;
        wdata = bus.ram_data;
      end
      if (bus.move_accept || bus.move_reject) begin
        done = 1;
        n    = k;
        acc  = bus.move_accept;
        rej  = bus.move_reject;
      end else begin
        @(negedge clk);
      end
    end
    chk("move_done", 32'(done), 32'd1);
    chk("accept", 32'(acc), 32'(legal));
    chk("reject", 32'(rej), 32'(!legal));
    if (legal) begin
      chk("accept_latency", 32'(n), 32'(2 * (row + 1) + 1));
      chk("write_count", 32'(writes), 32'd1);
      chk("write_addr", 32'(waddr), 32'(row * 7 + col));
      chk("write_data", 32'(wdata), (m_turn != 0) ? 32'd2 : 32'd1);
      cells[row * 7 + col] = (m_turn != 0) ? 2'b10 : 2'b01;
      heights[col]++;
      m_moves++;
      m_turn = 1 - m_turn;
    end else begin
      chk("reject_latency", 32'(n), (col >= 7) ? 32'd1 : 32'd15);
      chk("reject_nowrite", 32'(writes), 32'd0);
    end
    @(negedge clk);
    chk("post_ready", 32'(bus.move_ready), 32'd1);
    chk("post_turn", 32'(bus.turn), 32'(m_turn));
    chk("post_moves", 32'(bus.moves_made), 32'(m_moves));
    chk("post_full", 32'(bus.board_full), 32'(m_moves == 49));
    if (legal) begin
      chk("last_row", 32'(bus.last_row), 32'(row));
      chk("last_col", 32'(bus.last_col), 32'(col));
    end
  endtask

  initial begin
    bus.new_game   = 1'b0;
    bus.move_valid = 1'b0;
    bus.move_col   = 3'd0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.move_ready), 32'd0);
    chk("rst_ramsel", 32'(bus.ram_sel), 32'd1);
    chk("rst_benable", 32'(bus.board_enable), 32'd0);
    chk("rst_turn", 32'(bus.turn), 32'd0);
    chk("rst_moves", 32'(bus.moves_made), 32'd0);
    chk("rst_accept", 32'(bus.move_accept), 32'd0);
    chk("rst_reject", 32'(bus.move_reject), 32'd0);
    rst_n = 1'b1;
    clear_check();
    compare_board();

    do_move(3);
    do_move(7);
    for (int i = 0; i < 8; i++) do_move(0);

`ifdef TURN_TIMER_EN
    begin
      int c;
      int w;
      c = 1;
      w = 0;
      while (!bus.move_reject && c < 40) begin
        if (bus.ram_wren) w++;
        @(negedge clk);
        c++;
      end
      chk("timer_cycles", 32'(c), 32'd16);
      chk("timer_nowrite", 32'(w + int'(bus.ram_wren)), 32'd0);
      @(negedge clk);
      m_turn = 1 - m_turn;
      chk("timer_turn", 32'(bus.turn), 32'(m_turn));
      chk("timer_pulse", 32'(bus.move_reject), 32'd0);
    end
`endif

    // new_game wins over a simultaneous move; then reset lands mid-clear.
    bus.new_game   = 1'b1;
    bus.move_valid = 1'b1;
    bus.move_col   = 3'd2;
    @(negedge clk);
    bus.new_game   = 1'b0;
    bus.move_valid = 1'b0;
    chk("ng_ready", 32'(bus.move_ready), 32'd0);
    chk("ng_wren", 32'(bus.ram_wren), 32'd1);
    chk("ng_addr", 32'(bus.ram_address), 32'd0);
    repeat (10) @(negedge clk);
    chk("ng_addr10", 32'(bus.ram_address), 32'd10);
    rst_n = 1'b0;
    #1;
    chk("midclr_addr", 32'(bus.ram_address), 32'd0);
    chk("midclr_ramsel", 32'(bus.ram_sel), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    clear_check();
    compare_board();

    for (int i = 0; i < 100; i++) do_move(int'($urandom_range(0, 7)));
    compare_board();

    new_game();
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 7; r++) do_move(c);
    do_move(4);
    do_move(6);
    compare_board();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
